reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 116 +++++++++++
 tb/tb_reg_file_mp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with per-register pending
// (scoreboard) bits and a registered pending-register count.
// Register 0 is hardwired to zero and can never become pending.
// Optional macro REG_FILE_MP_BYPASS_EN forwards a same-cycle write to readers.

module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [ADDR_W:0]   r_pend_cnt;

  logic [DEPTH-1:0]  w_pend_next;
  logic [ADDR_W:0]   w_cnt_next;
  logic              w_wr_en;
  logic              w_iss_en;
  logic              w_iss_new;
  logic              w_clr_drop;

  // Writes and issues to register 0 are ignored; flush suppresses issue.
  assign w_wr_en  = we && (wa != '0);
  assign w_iss_en = iss_valid && (iss_addr != '0) && !flush;

  // A set only counts when the bit was clear; a clear only counts when the bit
  // was set and a same-address issue does not immediately re-set it.
  assign w_iss_new  = w_iss_en && !r_pend[iss_addr];
  assign w_clr_drop = w_wr_en && r_pend[wa] && !(w_iss_en && (iss_addr == wa));

  // Next pending vector: write clears, issue sets (issue wins), flush clears all.
  always_comb begin
    w_pend_next = r_pend;
    if (w_wr_en) begin
      w_pend_next[wa] = 1'b0;
    end
    if (w_iss_en) begin
      w_pend_next[iss_addr] = 1'b1;
    end
    if (flush) begin
      w_pend_next = '0;
    end
  end

  // Incremental pending count, kept equal to the popcount of the pending bits.
  always_comb begin
    w_cnt_next = r_pend_cnt;
    if (flush) begin
      w_cnt_next = '0;
    end else begin
      case ({w_iss_new, w_clr_drop})
        2'b10:   w_cnt_next = r_pend_cnt + CNT_ONE;
        2'b01:   w_cnt_next = r_pend_cnt - CNT_ONE;
        default: w_cnt_next = r_pend_cnt;
      endcase
    end
  end

  // Data storage; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[wa] <= wd;
    end
  end

  // Pending bits and their count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_next;
      r_pend_cnt <= w_cnt_next;
    end
  end

  assign pend_cnt = r_pend_cnt;

  // Independent combinational read ports.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = ra[gi*ADDR_W +: ADDR_W];
`ifdef REG_FILE_MP_BYPASS_EN
    // Forwarding is suppressed while reset is asserted so readers see zero.
    logic w_byp;
    assign w_byp = rst_n && w_wr_en && (wa == w_ra);
    assign rd[gi*DATA_W +: DATA_W] = w_byp ? wd : r_mem[w_ra];
    assign rd_busy[gi]             = w_byp ? 1'b0 : r_pend[w_ra];
`else
    assign rd[gi*DATA_W +: DATA_W] = r_mem[w_ra];
    assign rd_busy[gi]             = r_pend[w_ra];
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp (default parameters: 32-bit data, 32 registers,
// 2 read ports). Directed scenarios followed by random traffic, all checked
// against an array-based reference model of the register file.

module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic           clk;
  logic           rst_n;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]  rd_busy;
  logic           we;
  logic [AW-1:0]  wa;
  logic [DW-1:0]  wd;
  logic           iss_valid;
  logic [AW-1:0]  iss_addr;
  logic           flush;
  logic [AW:0]    pend_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .flush(flush), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef REG_FILE_MP_BYPASS_EN
    if (we && wa == a && a != 0) return wd;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REG_FILE_MP_BYPASS_EN
    if (we && wa == a && a != 0) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  function automatic logic [AW-1:0] port_ra(input int p);
    return ra[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] port_rd(input int p);
    return rd[p*DW +: DW];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Apply the effect of one clock edge to the model.
  task automatic model_edge();
    if (we && wa != 0) begin
      m_mem[wa]  = wd;
      m_pend[wa] = 1'b0;
    end
    if (iss_valid && iss_addr != 0 && !flush) m_pend[iss_addr] = 1'b1;
    if (flush) for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    for (int p = 0; p < NR; p++) begin
      check($sformatf("%s_rd%0d[a=%0d]", tag, p, port_ra(p)), 64'(port_rd(p)), 64'(exp_rd(port_ra(p))));
      check($sformatf("%s_busy%0d[a=%0d]", tag, p, port_ra(p)), 64'(rd_busy[p]), 64'(exp_busy(port_ra(p))));
    end
    check($sformatf("%s_pend_cnt", tag), 64'(pend_cnt), 64'(model_cnt()));
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  // Inputs are applied before calling; checks combinational outputs, then clocks.
  task automatic cycle(input string tag);
    #1;
    check_outputs(tag);
    $display("txn %s: we=%0d wa=%0d wd=0x%0h iss=%0d ia=%0d flush=%0d ra0=%0d ra1=%0d pend_cnt=%0d",
             tag, we, wa, wd, iss_valid, iss_addr, flush, port_ra(0), port_ra(1), pend_cnt);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_ra(5'd3, 5'd0);
    model_clear();
    #2;
    check("reset_rd0", 64'(port_rd(0)), 64'd0);
    check("reset_busy", 64'(rd_busy), 64'd0);
    check("reset_pend_cnt", 64'(pend_cnt), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read
    we = 1; wa = 5; wd = 32'hDEADBEEF; set_ra(5'd1, 5'd2);
    cycle("wr_x5");
    idle(); set_ra(5'd5, 5'd5);
    #1;
    check("x5_rd0", 64'(port_rd(0)), 64'hDEADBEEF);
    check("x5_rd1_same", 64'(port_rd(1)), 64'hDEADBEEF);
    check("x5_busy", 64'(rd_busy[0]), 64'd0);
    cycle("rd_x5");

    // x0 protection
    we = 1; wa = 0; wd = 32'hFFFFFFFF; iss_valid = 1; iss_addr = 0; set_ra(5'd0, 5'd0);
    cycle("x0_wr_iss");
    idle();
    #1;
    check("x0_rd", 64'(port_rd(0)), 64'd0);
    check("x0_busy", 64'(rd_busy[0]), 64'd0);
    check("x0_pend_cnt", 64'(pend_cnt), 64'd0);
    cycle("x0_rd");

    // Scoreboard: issue then writeback
    iss_valid = 1; iss_addr = 7; set_ra(5'd7, 5'd5);
    cycle("iss_x7");
    idle();
    #1;
    check("x7_busy", 64'(rd_busy[0]), 64'd1);
    check("x7_pend_cnt", 64'(pend_cnt), 64'd1);
    we = 1; wa = 7; wd = 32'h12; set_ra(5'd6, 5'd5);
    cycle("wr_x7");
    idle(); set_ra(5'd7, 5'd7);
    #1;
    check("x7_busy_clr", 64'(rd_busy[0]), 64'd0);
    check("x7_pend_cnt_clr", 64'(pend_cnt), 64'd0);
    check("x7_data", 64'(port_rd(0)), 64'h12);
    cycle("rd_x7");

    // Simultaneous issue and write on a pending register
    iss_valid = 1; iss_addr = 3; set_ra(5'd1, 5'd2);
    cycle("iss_x3");
    iss_valid = 1; iss_addr = 3; we = 1; wa = 3; wd = 32'hA5;
    cycle("iss_wr_x3");
    idle(); set_ra(5'd3, 5'd0);
    #1;
    check("x3_data", 64'(port_rd(0)), 64'hA5);
    check("x3_busy", 64'(rd_busy[0]), 64'd1);
    check("x3_pend_cnt", 64'(pend_cnt), 64'd1);
    flush = 1; iss_valid = 1; iss_addr = 9;
    cycle("flush");
    idle();
    #1;
    check("flush_pend_cnt", 64'(pend_cnt), 64'd0);
    check("flush_x3_busy", 64'(rd_busy[0]), 64'd0);
    cycle("post_flush");

    // Same-cycle write and read of x9
    we = 1; wa = 9; wd = 32'h55; set_ra(5'd9, 5'd8);
    #1;
`ifdef REG_FILE_MP_BYPASS_EN
    check("byp_x9", 64'(port_rd(0)), 64'h55);
`else
    check("nobyp_x9", 64'(port_rd(0)), 64'h0);
`endif
    cycle("wr_x9");
    idle();

    // Mid-operation reset
    for (int i = 1; i <= 4; i++) begin
      we = 1; wa = AW'(i); wd = 32'h100 + 32'(i);
      cycle($sformatf("wr_x%0d", i));
    end
    idle(); iss_valid = 1; iss_addr = 2;
    cycle("iss_x2");
    idle(); we = 1; wa = 6; wd = 32'h77; iss_valid = 1; iss_addr = 8; set_ra(5'd2, 5'd6);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd0", 64'(port_rd(0)), 64'd0);
    check("rst_rd1", 64'(port_rd(1)), 64'd0);
    check("rst_busy", 64'(rd_busy), 64'd0);
    check("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    $display("txn mid_reset: rd0=0x%0h rd1=0x%0h busy=%0b pend_cnt=%0d", port_rd(0), port_rd(1), rd_busy, pend_cnt);
    model_clear();
    @(posedge clk); #1;
    check("rst_hold_x6", 64'(port_rd(1)), 64'd0);
    check("rst_hold_cnt", 64'(pend_cnt), 64'd0);
    #3 rst_n = 1'b1;
    #1 set_ra(5'd6, 5'd4);
    cycle("first_wr_x6");
    idle();
    #1;
    check("first_wr_x6_data", 64'(port_rd(0)), 64'h77);
    check("x4_cleared", 64'(port_rd(1)), 64'd0);
    cycle("rd_x6");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      we        = 1'($urandom_range(0, 1));
      wa        = AW'($urandom_range(0, DEPTH-1));
      wd        = DW'($urandom);
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = ($urandom_range(0, 5) == 0) ? wa : AW'($urandom_range(0, DEPTH-1));
      flush     = ($urandom_range(0, 15) == 0);
      set_ra(($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH-1)),
             AW'($urandom_range(0, DEPTH-1)));
      cycle($sformatf("rnd%0d", n));
    end
    idle();
    cycle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
